// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are served in the request cycle. Misses run a write-back/refill FSM while cpu_stall_o is held high.
module dcache_ctrl #(
    parameter int LINES   = 16,
    parameter int BLOCK_W = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    input  logic               cpu_MemRead_i,
    input  logic               cpu_MemWrite_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int WORDS  = BLOCK_W / 32;
    localparam int WORD_W = $clog2(WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, REFILL_DONE} state_t;

    state_t             state_reg;
    logic [LINES-1:0]   valid_reg;
    logic [LINES-1:0]   dirty_reg;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [BLOCK_W-1:0] data_mem [LINES];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  word;
    logic [BLOCK_W-1:0] cur_line;
    logic [31:0]        line_words [WORDS];
    logic               req;
    logic               hit;
    logic               miss;
    logic               store_hit;
    logic               refill_ack;
    logic               unused_addr_bits;

    assign req_tag          = cpu_addr_i[31 -: TAG_W];
    assign idx              = cpu_addr_i[OFF_W +: IDX_W];
    assign word             = cpu_addr_i[2 +: WORD_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign cur_line = data_mem[idx];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign line_words[gi] = cur_line[gi*32 +: 32];
        end
    endgenerate

    assign req        = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit        = valid_reg[idx] & (tag_mem[idx] == req_tag);
    assign miss       = req & ~hit;
    assign store_hit  = (state_reg == IDLE) & cpu_MemWrite_i & hit;
    assign refill_ack = (state_reg == REFILL) & mem_ack_i;

    // Loads only return data when actually served, i.e. in IDLE; a combined load+store sees the pre-store word.
    assign cpu_data_o  = ((state_reg == IDLE) & cpu_MemRead_i & hit) ? line_words[word] : 32'd0;
    assign cpu_stall_o = miss | (state_reg != IDLE);

    // Tag/data arrays carry no reset; only valid/dirty must be cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refill_ack) begin
                data_mem[idx] <= mem_data_i;
                tag_mem[idx]  <= req_tag;
            end else if (store_hit) begin
                data_mem[idx][{word, 5'b0} +: 32] <= cpu_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            valid_reg    <= '0;
            dirty_reg    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_data_o   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (store_hit) begin
                        dirty_reg[idx] <= 1'b1;
                    end
                    if (miss) begin
                        mem_enable_o <= 1'b1;
                        if (valid_reg[idx] & dirty_reg[idx]) begin
                            state_reg   <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
                            mem_data_o  <= cur_line;
                        end else begin
                            state_reg   <= REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
                            mem_data_o  <= '0;
                        end
                    end
                end
                WRITEBACK: begin
                    // Victim is out; switch the still-enabled port straight to the refill read.
                    if (mem_ack_i) begin
                        state_reg   <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
                        mem_data_o  <= '0;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_reg      <= REFILL_DONE;
                        mem_enable_o   <= 1'b0;
                        mem_addr_o     <= 32'd0;
                        valid_reg[idx] <= 1'b1;
                        dirty_reg[idx] <= 1'b0;
                    end
                end
                REFILL_DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: CPU op table with hand-derived expectations, a memory responder
// with a backing store, and a queue of expected memory transactions checked as they appear.
module tb_dcache_ctrl;
    logic         clk;
    logic         rst;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_en;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    dcache_ctrl #(.LINES(16), .BLOCK_W(256)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_addr_i    (addr),
        .cpu_data_i    (wdata),
        .cpu_MemRead_i (rd),
        .cpu_MemWrite_i(wr),
        .cpu_data_o    (rdata),
        .cpu_stall_o   (stall),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (mem_ack)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;
        logic [31:0] exp_data;
        logic        wb;
        logic [31:0] wb_addr;
        int          wb_sel;
        logic [31:0] wb_val;
        logic        rf;
        logic [31:0] rf_addr;
    } vec_t;

    txn_t         exp_q[$];
    vec_t         vecs[$];
    logic [255:0] backing [logic [31:0]];
    int           total;
    int           bad;
    int           ack_delay;
    bit           resp_en;
    bit           busy;
    int           cnt;
    txn_t         cur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

    // Memory block contents before any write-back: word w of block a is 0xA000_0000 | a | w.
    function automatic logic [255:0] pat_block(logic [31:0] a);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'hA000_0000 | a | 32'(w);
        return b;
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Memory responder, run once per cycle at the falling edge: ack ack_delay cycles into each request.
    task automatic mem_tick();
        txn_t e;
        mem_ack   = 1'b0;
        mem_rdata = {8{32'hBAD0_0BAD}};
        if (rst || !resp_en || !mem_en) begin
            busy = 1'b0;
            if (!mem_en) begin
                chk("idle_mem_we", 256'(mem_we), 256'(0));
                chk("idle_mem_addr", 256'(mem_addr), 256'(0));
                chk("idle_mem_data", mem_wdata, 256'(0));
            end
        end else begin
            if (!busy) begin
                busy     = 1'b1;
                cnt      = 0;
                cur.wr   = mem_we;
                cur.addr = mem_addr;
                cur.data = mem_wdata;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_txn_unexpected: got we=%0b addr=%h want no transaction", mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_txn_we", 256'(mem_we), 256'(e.wr));
                    chk("mem_txn_addr", 256'(mem_addr), 256'(e.addr));
                    chk("mem_txn_data", mem_wdata, e.data);
                end
            end else begin
                chk("mem_hold_we", 256'(mem_we), 256'(cur.wr));
                chk("mem_hold_addr", 256'(mem_addr), 256'(cur.addr));
                chk("mem_hold_data", mem_wdata, cur.data);
            end
            cnt++;
            if (cnt >= ack_delay) begin
                mem_ack = 1'b1;
                if (cur.wr) backing[cur.addr] = cur.data;
                else mem_rdata = backing.exists(cur.addr) ? backing[cur.addr] : pat_block(cur.addr);
                busy = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mem_tick();
    endtask

    task automatic add(string name, logic r, logic w, logic [31:0] a, logic [31:0] d, int es,
                       logic [31:0] ed, logic wb, logic [31:0] wba, int wbs, logic [31:0] wbv,
                       logic rf, logic [31:0] rfa);
        vec_t v;
        v.name = name; v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
        v.exp_stall = es; v.exp_data = ed;
        v.wb = wb; v.wb_addr = wba; v.wb_sel = wbs; v.wb_val = wbv;
        v.rf = rf; v.rf_addr = rfa;
        vecs.push_back(v);
    endtask

    task automatic do_op(vec_t v);
        int   stalls;
        txn_t t;
        if (v.wb) begin
            t.wr   = 1'b1;
            t.addr = v.wb_addr;
            t.data = pat_block(v.wb_addr);
            t.data[v.wb_sel*32 +: 32] = v.wb_val;
            exp_q.push_back(t);
        end
        if (v.rf) begin
            t.wr   = 1'b0;
            t.addr = v.rf_addr;
            t.data = '0;
            exp_q.push_back(t);
        end
        cycle();
        rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
        #1;
        stalls = 0;
        while (stall === 1'b1 && stalls < 200) begin
            stalls++;
            cycle();
            #1;
        end
        chk({v.name, "_stall_cycles"}, 256'(stalls), 256'(v.exp_stall));
        chk({v.name, "_data"}, 256'(rdata), 256'(v.exp_data));
        chk({v.name, "_txns_pending"}, 256'(exp_q.size()), 256'(0));
        $display("op %s rd=%0b wr=%0b addr=%h stall_cycles=%0d data=%h", v.name, v.rd, v.wr, v.addr, stalls, rdata);
    endtask

    initial begin
        total = 0; bad = 0; ack_delay = 3; resp_en = 1'b1; busy = 1'b0; cnt = 0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = '0;

        //   name              rd wr addr          wdata          stall data           wb wb_addr   sel wb_val         rf rf_addr
        add("cold_load",       1, 0, 32'h0000_0104, 32'h0,         5, 32'hA000_0101, 0, 32'h0,    0, 32'h0,          1, 32'h0000_0100);
        add("store_hit",       0, 1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,    0, 32'h0,          0, 32'h0);
        add("load_hit",        1, 0, 32'h0000_0104, 32'h0,         0, 32'hDEAD_BEEF, 0, 32'h0,    0, 32'h0,          0, 32'h0);
        add("load_store_miss", 1, 1, 32'h0000_0A08, 32'h0000_0055, 5, 32'hA000_0A02, 0, 32'h0,    0, 32'h0,          1, 32'h0000_0A00);
        add("load_after_ls",   1, 0, 32'h0000_0A08, 32'h0,         0, 32'h0000_0055, 0, 32'h0,    0, 32'h0,          0, 32'h0);
        add("dirty_evict",     1, 0, 32'h0000_0304, 32'h0,         8, 32'hA000_0301, 1, 32'h100,  1, 32'hDEAD_BEEF,  1, 32'h0000_0300);
        add("clean_evict",     1, 0, 32'h0000_0104, 32'h0,         5, 32'hDEAD_BEEF, 0, 32'h0,    0, 32'h0,          1, 32'h0000_0100);
        add("post_rst_load",   1, 0, 32'h0000_0A08, 32'h0,         5, 32'hA000_0A02, 0, 32'h0,    0, 32'h0,          1, 32'h0000_0A00);
        add("store_miss",      0, 1, 32'h0000_0508, 32'h1234_5678, 5, 32'h0,         0, 32'h0,    0, 32'h0,          1, 32'h0000_0500);
        add("load_stored",     1, 0, 32'h0000_0508, 32'h0,         0, 32'h1234_5678, 0, 32'h0,    0, 32'h0,          0, 32'h0);
        add("reload_evict",    1, 0, 32'h0000_0104, 32'h0,         8, 32'hDEAD_BEEF, 1, 32'h500,  2, 32'h1234_5678,  1, 32'h0000_0100);
        add("neighbour_hit",   1, 0, 32'h0000_0108, 32'h0,         0, 32'hA000_0102, 0, 32'h0,    0, 32'h0,          0, 32'h0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_stall", 256'(stall), 256'(0));
        chk("reset_mem_en", 256'(mem_en), 256'(0));
        chk("reset_mem_we", 256'(mem_we), 256'(0));
        chk("reset_mem_addr", 256'(mem_addr), 256'(0));
        chk("reset_mem_data", mem_wdata, 256'(0));
        chk("reset_cpu_data", 256'(rdata), 256'(0));

        for (int i = 0; i < 7; i++) do_op(vecs[i]);

        // Reset in the middle of a refill, then a late ack that must be ignored.
        resp_en = 1'b0;
        cycle();
        rd = 1'b1; wr = 1'b0; addr = 32'h0000_0904;
        #1;
        chk("midmiss_stall", 256'(stall), 256'(1));
        repeat (3) cycle();
        #1;
        chk("midmiss_mem_en", 256'(mem_en), 256'(1));
        chk("midmiss_mem_we", 256'(mem_we), 256'(0));
        chk("midmiss_mem_addr", 256'(mem_addr), 256'(32'h0000_0900));
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; rd = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("midmiss_rst_stall", 256'(stall), 256'(0));
        chk("midmiss_rst_mem_en", 256'(mem_en), 256'(0));
        chk("midmiss_rst_mem_we", 256'(mem_we), 256'(0));
        chk("midmiss_rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("midmiss_rst_mem_data", mem_wdata, 256'(0));
        cycle();
        #1;
        chk("late_ack_mem_en", 256'(mem_en), 256'(0));
        chk("late_ack_stall", 256'(stall), 256'(0));
        $display("op reset_mid_miss addr=%h mem_en=%0b stall=%0b", addr, mem_en, stall);
        resp_en = 1'b1;

        for (int i = 7; i < vecs.size(); i++) do_op(vecs[i]);

        cycle();
        rd = 1'b0; wr = 1'b0;
        repeat (5) cycle();
        #1;
        chk("final_stall", 256'(stall), 256'(0));
        chk("final_txns_pending", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
